// File: rtl/ram_dma_bus_master_if.sv
// System-bus signal bundle for the scratch-memory DMA initiator.
// master: driven by the DMA engine (request, burst start, address/data, write strobes).
// slave:  driven by the arbiter/responder (grant, read data, end of read burst, busy, error).
interface ram_dma_bus_master_if;
  logic        requestTransaction;
  logic        transactionGranted;
  logic        beginTransactionOut;
  logic [31:0] addressDataOut;
  logic        readNotWriteOut;
  logic [7:0]  burstSizeOut;
  logic [3:0]  byteEnablesOut;
  logic        dataValidOut;
  logic        endTransactionOut;
  logic [31:0] addressDataIn;
  logic        dataValidIn;
  logic        endTransactionIn;
  logic        busyIn;
  logic        errorIn;

  modport master (
    output requestTransaction, beginTransactionOut, addressDataOut, readNotWriteOut,
           burstSizeOut, byteEnablesOut, dataValidOut, endTransactionOut,
    input  transactionGranted, addressDataIn, dataValidIn, endTransactionIn, busyIn, errorIn
  );

  modport slave (
    input  requestTransaction, beginTransactionOut, addressDataOut, readNotWriteOut,
           burstSizeOut, byteEnablesOut, dataValidOut, endTransactionOut,
    output transactionGranted, addressDataIn, dataValidIn, endTransactionIn, busyIn, errorIn
  );
endinterface

// File: rtl/ram_dma_bus_master.sv
// Bus-side end of the CI scratch-memory DMA path. Owns port B of the CI dual-port
// SSRAM and moves word blocks between it and system-bus memory as a burst initiator.
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   start/ciN/valueA/valueB      custom-instruction request (valueA[12:10] select, [9] write)
//   done/result                  CI completion one cycle after acceptance, read data
//   memAddress/memWriteEnable/
//   memDataOut/memDataIn         SSRAM port B (read data one cycle after address)
//   bus                          system-bus initiator signals (master modport)
module ram_dma_bus_master #(
  parameter logic [7:0] customId = 8'h00,
  parameter int         memAddrW = 9
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          ciN,
  input  logic [31:0]         valueA,
  input  logic [31:0]         valueB,
  output logic                done,
  output logic [31:0]         result,
  output logic [memAddrW-1:0] memAddress,
  output logic                memWriteEnable,
  output logic [31:0]         memDataOut,
  input  logic [31:0]         memDataIn,
  ram_dma_bus_master_if.master bus
);

  typedef enum logic [2:0] {
    stIdle, stRequest, stBegin, stReadData, stWriteData, stWriteEnd, stGap
  } stateT;

  stateT state, stateNext;

  logic [31:0]         busAddr;
  logic [memAddrW-1:0] memAddr;
  logic [9:0]          blockSize;   // words still to transfer; live during a transfer
  logic [7:0]          burstSize;
  logic                errorFlag;
  logic                dirRead;     // 1: bus -> memory
  logic [8:0]          wordsLeft;   // words of the current write burst not yet accepted

  logic       ciAccept, ciWrite, idle, startReq, startXfer;
  logic [2:0] ciSel;
  logic [9:0] burstLen, burstWords, burstWordsM1;
  logic [31:0] readData;
  logic       unusedBits;

  assign ciSel     = valueA[12:10];
  assign ciWrite   = valueA[9];
  assign ciAccept  = start && (ciN == customId) && (ciSel != 3'b000);
  assign idle      = (state == stIdle);
  assign startReq  = ciAccept && ciWrite && (ciSel == 3'd5) && idle && (valueB[0] || valueB[1]);
  assign startXfer = startReq && (blockSize != 10'd0);

  // Burst length is clipped to what is left of the block.
  assign burstLen     = {2'b00, burstSize} + 10'd1;
  assign burstWords   = (burstLen > blockSize) ? blockSize : burstLen;
  assign burstWordsM1 = burstWords - 10'd1;

  assign unusedBits = ^{valueA[31:13], valueA[8:0], burstWordsM1[9:8]};

  always_comb begin
    readData = '0;
    case (ciSel)
      3'd1:    readData = busAddr;
      3'd2:    readData = 32'(memAddr);
      3'd3:    readData = {22'b0, blockSize};
      3'd4:    readData = {24'b0, burstSize};
      3'd5:    readData = {30'b0, errorFlag, !idle};
      default: readData = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= stIdle;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext                = state;
    bus.requestTransaction   = 1'b0;
    bus.beginTransactionOut  = 1'b0;
    bus.addressDataOut       = '0;
    bus.readNotWriteOut      = 1'b0;
    bus.burstSizeOut         = '0;
    bus.byteEnablesOut       = '0;
    bus.dataValidOut         = 1'b0;
    bus.endTransactionOut    = 1'b0;
    memAddress               = '0;
    memWriteEnable           = 1'b0;
    memDataOut               = '0;
    unique case (state)
      stIdle: if (startXfer) stateNext = stRequest;
      stRequest: begin
        bus.requestTransaction = 1'b1;
        if (bus.transactionGranted) stateNext = stBegin;
      end
      stBegin: begin
        bus.requestTransaction  = 1'b1;
        bus.beginTransactionOut = 1'b1;
        bus.addressDataOut      = busAddr;
        bus.readNotWriteOut     = dirRead;
        bus.burstSizeOut        = burstWordsM1[7:0];
        bus.byteEnablesOut      = 4'hF;
        memAddress              = memAddr;  // first write word arrives next cycle
        stateNext               = dirRead ? stReadData : stWriteData;
      end
      stReadData: begin
        bus.requestTransaction = 1'b1;
        memAddress             = memAddr;
        if (bus.dataValidIn) begin
          memWriteEnable = 1'b1;
          memDataOut     = bus.addressDataIn;
        end
        if (bus.endTransactionIn) stateNext = (blockSize == 10'd0) ? stIdle : stGap;
      end
      stWriteData: begin
        bus.requestTransaction = 1'b1;
        bus.dataValidOut       = 1'b1;
        bus.addressDataOut     = memDataIn;
        // Re-read the shown word while the responder stalls, else prefetch the next one.
        memAddress = bus.busyIn ? memAddr : memAddr + memAddrW'(1);
        if (!bus.busyIn && (wordsLeft == 9'd1)) stateNext = stWriteEnd;
      end
      stWriteEnd: begin
        bus.requestTransaction = 1'b1;
        bus.endTransactionOut  = 1'b1;
        stateNext              = (blockSize == 10'd0) ? stIdle : stGap;
      end
      stGap:   stateNext = stRequest;  // request dropped for one cycle between bursts
      default: stateNext = stIdle;
    endcase
    if (!idle && bus.errorIn) stateNext = stIdle;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      done      <= 1'b0;
      result    <= '0;
      busAddr   <= '0;
      memAddr   <= '0;
      blockSize <= '0;
      burstSize <= '0;
      errorFlag <= 1'b0;
      dirRead   <= 1'b0;
      wordsLeft <= '0;
    end else begin
      done   <= ciAccept;
      result <= (ciAccept && !ciWrite) ? readData : '0;
      if (ciAccept && ciWrite && idle) begin
        case (ciSel)
          3'd1:    busAddr   <= {valueB[31:2], 2'b00};
          3'd2:    memAddr   <= valueB[memAddrW-1:0];
          3'd3:    blockSize <= valueB[9:0];
          3'd4:    burstSize <= valueB[7:0];
          default: ;
        endcase
      end
      if (startReq) begin
        errorFlag <= 1'b0;
        dirRead   <= valueB[0];
      end
      if (!idle && bus.errorIn) begin
        errorFlag <= 1'b1;
      end else begin
        case (state)
          stBegin: begin
            busAddr   <= busAddr + {20'b0, burstWords, 2'b00};
            blockSize <= blockSize - burstWords;
            wordsLeft <= burstWords[8:0];
          end
          stReadData: if (bus.dataValidIn) memAddr <= memAddr + memAddrW'(1);
          stWriteData: if (!bus.busyIn) begin
            memAddr   <= memAddr + memAddrW'(1);
            wordsLeft <= wordsLeft - 9'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_dma_bus_master.sv
// Self-checking bench for ram_dma_bus_master: CI driver, SSRAM model, bus responder
// and a block-level reference model of the expected bursts and memory image.
module tb_ram_dma_bus_master;
  logic        clock = 1'b0;
  logic        reset, start;
  logic [7:0]  ciN;
  logic [31:0] valueA, valueB;
  logic        done;
  logic [31:0] result;
  logic [8:0]  memAddress;
  logic        memWriteEnable;
  logic [31:0] memDataOut, memDataIn;

  ram_dma_bus_master_if bus();

  ram_dma_bus_master #(.customId(8'h00), .memAddrW(9)) dut (
    .clock(clock), .reset(reset), .start(start), .ciN(ciN), .valueA(valueA), .valueB(valueB),
    .done(done), .result(result), .memAddress(memAddress), .memWriteEnable(memWriteEnable),
    .memDataOut(memDataOut), .memDataIn(memDataIn), .bus(bus)
  );

  always #5 clock = ~clock;

  // SSRAM port-B model: synchronous read, write strobe.
  logic [31:0] memArr [0:511];
  logic [31:0] memRef [0:511];
  logic        memFill;
  always @(posedge clock) begin
    if (memFill) for (int i = 0; i < 512; i++) memArr[i] <= $urandom;
    else if (memWriteEnable) memArr[memAddress] <= memDataOut;
    memDataIn <= memArr[memAddress];
  end

  int testsRun = 0;
  int testsFailed = 0;

  task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] busWord(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [63:0] allOutputs();
    return {done, result[15:0] | result[31:16], memAddress, memWriteEnable, |memDataOut,
            bus.requestTransaction, bus.beginTransactionOut, |bus.addressDataOut,
            bus.readNotWriteOut, bus.burstSizeOut, bus.byteEnablesOut,
            bus.dataValidOut, bus.endTransactionOut};
  endfunction

  // Called and returning just after a falling edge.
  task automatic ciOp(input bit wr, input logic [2:0] sel, input logic [31:0] data,
                      output logic [31:0] res);
    start  = 1'b1;
    ciN    = 8'h00;
    valueA = (32'(sel) << 10) | (32'(wr) << 9);
    valueB = data;
    @(negedge clock);
    start = 1'b0; valueA = '0; valueB = '0;
    checkValue("ciDone", done, 1'b1);
    res = result;
  endtask

  task automatic ciRead(input logic [2:0] sel, input logic [31:0] exp, input string tag);
    logic [31:0] r;
    ciOp(1'b0, sel, 32'h0, r);
    checkValue(tag, r, exp);
  endtask

  task automatic runTransfer(input bit isRead, input logic [31:0] busRaw, input int memA,
                             input int n, input int lenVal, input int busyMode,
                             input logic [31:0] ctrl, input int errBurst, output bit aborted);
    logic [31:0] r, busA, addr, expWord;
    int rem, w, idx, got, cyc, busyCnt, bad, d;
    bit busy;
    aborted = 1'b0;
    busA = busRaw & ~32'h3;
    for (int i = 0; i < 512; i++) memRef[i] = memArr[i];
    ciOp(1'b1, 3'd1, busRaw, r);
    ciOp(1'b1, 3'd2, 32'(memA), r);
    ciOp(1'b1, 3'd3, 32'(n), r);
    ciOp(1'b1, 3'd4, 32'(lenVal), r);
    ciOp(1'b1, 3'd5, ctrl, r);
    rem = n; addr = busA; idx = 0; busyCnt = 0;
    for (int b = 0; rem > 0; b++) begin
      w = (lenVal + 1 < rem) ? lenVal + 1 : rem;
      cyc = 0;
      while (bus.requestTransaction !== 1'b1 && cyc < 20) begin @(negedge clock); cyc++; end
      checkValue("request", bus.requestTransaction, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clock);
      bus.transactionGranted = 1'b1;
      @(negedge clock);
      bus.transactionGranted = 1'b0;
      checkValue("begin", bus.beginTransactionOut, 1'b1);
      checkValue("beginAddr", bus.addressDataOut, addr);
      checkValue("beginRnw", bus.readNotWriteOut, isRead);
      checkValue("beginSize", bus.burstSizeOut, 8'(w - 1));
      checkValue("beginBe", bus.byteEnablesOut, 4'hF);
      @(negedge clock);
      if (isRead) begin
        bit endTogether;
        endTogether = 1'($urandom_range(0, 1));
        for (int k = 0; k < w; k++) begin
          repeat ($urandom_range(0, 1)) @(negedge clock);
          if (b == errBurst && k == 1) begin
            bus.errorIn = 1'b1;
            @(negedge clock);
            bus.errorIn = 1'b0;
            checkValue("errBusIdle", allOutputs(), 64'h0);
            aborted = 1'b1;
            return;
          end
          bus.addressDataIn    = busWord(addr + 32'(4 * k));
          bus.dataValidIn      = 1'b1;
          bus.endTransactionIn = (k == w - 1) && endTogether;
          @(negedge clock);
          bus.dataValidIn = 1'b0; bus.endTransactionIn = 1'b0; bus.addressDataIn = '0;
        end
        if (!endTogether) begin
          bus.endTransactionIn = 1'b1;
          @(negedge clock);
          bus.endTransactionIn = 1'b0;
        end
      end else begin
        got = 0; cyc = 0;
        while (got < w && cyc < 100) begin
          checkValue("wValid", bus.dataValidOut, 1'b1);
          expWord = memRef[(memA + idx) % 512];
          checkValue("wWord", bus.addressDataOut, expWord);
          case (busyMode)
            1:       busy = ($urandom_range(0, 2) == 0);
            2:       busy = (idx == 1) && (busyCnt < 3);
            default: busy = 1'b0;
          endcase
          if (busy) busyCnt++;
          bus.busyIn = busy;
          @(negedge clock);
          if (!busy) begin idx++; got++; end
          cyc++;
        end
        bus.busyIn = 1'b0;
        checkValue("wCount", got, w);
        checkValue("wEnd", {bus.endTransactionOut, bus.dataValidOut, bus.requestTransaction}, 3'b101);
        @(negedge clock);
      end
      checkValue("reqDropped", bus.requestTransaction, 1'b0);
      rem -= w;
      addr += 32'(4 * w);
    end
    // Expected memory image: reads land at consecutive wrapped addresses, writes leave memory alone.
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      expWord = memRef[i];
      d = (i - memA + 512) % 512;
      if (isRead && d < n) expWord = busWord(busA + 32'(4 * d));
      if (memArr[i] !== expWord) bad++;
    end
    checkValue("memImage", bad, 0);
    ciRead(3'd1, busA + 32'(4 * n), "rdBusAddr");
    ciRead(3'd2, 32'((memA + n) % 512), "rdMemAddr");
    ciRead(3'd3, 32'h0, "rdRemaining");
    ciRead(3'd4, 32'(lenVal), "rdBurst");
    ciRead(3'd5, 32'h0, "rdStatus");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    bit ab;
    reset = 1'b1; start = 1'b0; ciN = '0; valueA = '0; valueB = '0; memFill = 1'b1;
    bus.transactionGranted = 1'b0; bus.addressDataIn = '0; bus.dataValidIn = 1'b0;
    bus.endTransactionIn = 1'b0; bus.busyIn = 1'b0; bus.errorIn = 1'b0;
    repeat (3) @(negedge clock);
    memFill = 1'b0;
    checkValue("resetOutputs", allOutputs(), 64'h0);
    reset = 1'b0;
    for (int s = 1; s <= 5; s++) ciRead(3'(s), 32'h0, "resetRegs");

    // Foreign opcode and select 0 are not answered.
    start = 1'b1; ciN = 8'h11; valueA = 32'd5 << 10;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    checkValue("foreignCiN", done, 1'b0);
    start = 1'b1; ciN = 8'h00; valueA = 32'h0;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    checkValue("selectZero", done, 1'b0);
    ciRead(3'd6, 32'h0, "rdSel6");

    // Two read bursts of four words from 0x1000.
    runTransfer(1'b1, 32'h0000_1000, 0, 8, 3, 0, 32'h1, -1, ab);
    // Write across the memory wrap with a three-cycle stall on the second word.
    runTransfer(1'b0, 32'h0000_8000, 510, 4, 3, 2, 32'h2, -1, ab);
    // Bursts 4,4,2 with the bus address wrapping through 2**32.
    runTransfer(1'b0, 32'hFFFF_FFF3, 37, 10, 3, 0, 32'h2, -1, ab);
    // Randomised transfers; control=3 must still select bus->mem.
    for (int t = 0; t < 8; t++) begin
      bit rd;
      rd = 1'($urandom_range(0, 1));
      runTransfer(rd, $urandom, $urandom_range(0, 511), $urandom_range(1, 24),
                  $urandom_range(0, 7), 1, rd ? ($urandom_range(0, 1) ? 32'h3 : 32'h1) : 32'h2,
                  -1, ab);
    end

    // Bus error in the second read burst, then a zero-length start clears it.
    runTransfer(1'b1, 32'h0000_4000, 200, 12, 3, 0, 32'h1, 1, ab);
    checkValue("errAborted", ab, 1'b1);
    ciRead(3'd5, 32'h2, "rdStatusErr");
    ciOp(1'b1, 3'd3, 32'h0, r);
    ciOp(1'b1, 3'd5, 32'h1, r);
    repeat (2) begin
      checkValue("zeroLenNoReq", bus.requestTransaction, 1'b0);
      @(negedge clock);
    end
    ciRead(3'd5, 32'h0, "rdStatusCleared");

    // Reset in the middle of a write burst.
    ciOp(1'b1, 3'd1, 32'h0000_2000, r);
    ciOp(1'b1, 3'd2, 32'd100, r);
    ciOp(1'b1, 3'd3, 32'd8, r);
    ciOp(1'b1, 3'd4, 32'd7, r);
    ciOp(1'b1, 3'd5, 32'h2, r);
    bus.transactionGranted = 1'b1;
    @(negedge clock);
    bus.transactionGranted = 1'b0;
    repeat (2) @(negedge clock);
    checkValue("midBurstValid", bus.dataValidOut, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    checkValue("resetMidOutputs", allOutputs(), 64'h0);
    reset = 1'b0;
    for (int s = 1; s <= 5; s++) ciRead(3'(s), 32'h0, "resetMidRegs");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
